shift_unit_iter: RTL and testbench

- Parametrised multi-cycle shifter for the processor datapath; generalises the fixed single-bit 64-bit left shift.
- Supports logical left, logical right, arithmetic right and rotate left, by a variable amount.
- Shifts at most STEP bits per clock, so area stays small.
- Sits beside the ALU under a start/busy/done handshake; the multiplier/divider control stalls on busy.

---
 rtl/shift_unit_iter.sv | 110 +++++++++++
 tb/tb_shift_unit_iter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_unit_iter.sv
// Iterative shifter (SLL/SRL/SRA/ROL) moving at most STEP bits per clock under a start/busy/done handshake.
// Latency ceil(amount/STEP)+2 cycles from accept to done; start is ignored while busy, flush aborts at once.
module shift_unit_iter #(
    parameter int WIDTH = 64,
    parameter int STEP  = 1,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [AMT_W-1:0] amount,
    input  logic [WIDTH-1:0] operand,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [1:0]       MODE_SLL = 2'b00;
    localparam logic [1:0]       MODE_SRL = 2'b01;
    localparam logic [1:0]       MODE_SRA = 2'b10;
    localparam logic [1:0]       MODE_ROL = 2'b11;
    localparam logic [AMT_W-1:0] STEP_A   = AMT_W'(STEP);
    localparam logic [AMT_W:0]   WIDTH_A  = (AMT_W+1)'(WIDTH);

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_data, w_data_nxt;
    logic [WIDTH-1:0] r_result, w_result_nxt;
    logic [AMT_W-1:0] r_rem, w_rem_nxt;
    logic [1:0]       r_mode, w_mode_nxt;
    logic [AMT_W-1:0] w_k;
    logic [AMT_W:0]   w_rot_back;
    logic [WIDTH-1:0] w_shifted;

    // The last partial step moves only the bits still remaining.
    assign w_k        = (r_rem < STEP_A) ? r_rem : STEP_A;
    assign w_rot_back = WIDTH_A - {1'b0, w_k};

    always_comb begin
        w_shifted = r_data;
        case (r_mode)
            MODE_SLL: w_shifted = r_data << w_k;
            MODE_SRL: w_shifted = r_data >> w_k;
            MODE_SRA: w_shifted = $unsigned($signed(r_data) >>> w_k);
            MODE_ROL: w_shifted = (r_data << w_k) | (r_data >> w_rot_back);
            default:  w_shifted = r_data;
        endcase
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_data_nxt   = r_data;
        w_rem_nxt    = r_rem;
        w_mode_nxt   = r_mode;
        w_result_nxt = r_result;
        if (flush) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_state_nxt = S_SHIFT;
                        w_data_nxt  = operand;
                        w_rem_nxt   = amount;
                        w_mode_nxt  = mode;
                    end
                end
                S_SHIFT: begin
                    if (r_rem == '0) begin
                        w_state_nxt  = S_DONE;
                        w_result_nxt = r_data;
                    end else begin
                        w_data_nxt = w_shifted;
                        w_rem_nxt  = r_rem - w_k;
                    end
                end
                S_DONE:  w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_data   <= '0;
            r_rem    <= '0;
            r_mode   <= '0;
            r_result <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_data   <= w_data_nxt;
            r_rem    <= w_rem_nxt;
            r_mode   <= w_mode_nxt;
            r_result <= w_result_nxt;
        end
    end

    assign busy   = (r_state != S_IDLE);
    assign done   = (r_state == S_DONE);
    assign result = r_result;

endmodule

// File: tb/tb_shift_unit_iter.sv
// Bench for shift_unit_iter: two instances (STEP=1 and STEP=4) share stimulus; a scoreboard checks result and done timing.
module tb_shift_unit_iter;

    localparam int STEP_A = 1;
    localparam int STEP_B = 4;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic [1:0]  mode;
    logic [5:0]  amount;
    logic [63:0] operand;
    logic        flush;
    logic        busy_a, done_a, busy_b, done_b;
    logic [63:0] res_a, res_b;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [63:0] res;
        int          cyc;
    } exp_t;
    exp_t qa[$];
    exp_t qb[$];

    typedef struct {
        logic [1:0]  m;
        logic [5:0]  a;
        logic [63:0] op;
        logic [63:0] ex;
    } vec_t;
    vec_t vecs[12];

    shift_unit_iter #(.WIDTH(64), .STEP(STEP_A)) u_dut_a (
        .clock(clock), .reset_n(reset_n), .start(start), .mode(mode),
        .amount(amount), .operand(operand), .flush(flush),
        .busy(busy_a), .done(done_a), .result(res_a)
    );

    shift_unit_iter #(.WIDTH(64), .STEP(STEP_B)) u_dut_b (
        .clock(clock), .reset_n(reset_n), .start(start), .mode(mode),
        .amount(amount), .operand(operand), .flush(flush),
        .busy(busy_b), .done(done_b), .result(res_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc = cyc + 1;

    function automatic logic [63:0] model(input logic [1:0] m, input int a, input logic [63:0] v);
        logic [63:0] x;
        x = v;
        for (int i = 0; i < a; i++) begin
            case (m)
                2'b00:   x = {x[62:0], 1'b0};
                2'b01:   x = {1'b0, x[63:1]};
                2'b10:   x = {x[63], x[63:1]};
                default: x = {x[62:0], x[63]};
            endcase
        end
        return x;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding expectation, value and cycle.
    always @(negedge clock) begin
        exp_t ea;
        exp_t eb;
        if (done_a) begin
            checks++;
            if (qa.size() == 0) begin
                failures++;
                $display("FAIL done_a_unexpected result=%h cyc=%0d", res_a, cyc);
            end else begin
                ea = qa.pop_front();
                if (res_a !== ea.res || cyc != ea.cyc) begin
                    failures++;
                    $display("FAIL done_a result=%h cyc=%0d required result=%h cyc=%0d", res_a, cyc, ea.res, ea.cyc);
                end
            end
        end
        if (done_b) begin
            checks++;
            if (qb.size() == 0) begin
                failures++;
                $display("FAIL done_b_unexpected result=%h cyc=%0d", res_b, cyc);
            end else begin
                eb = qb.pop_front();
                if (res_b !== eb.res || cyc != eb.cyc) begin
                    failures++;
                    $display("FAIL done_b result=%h cyc=%0d required result=%h cyc=%0d", res_b, cyc, eb.res, eb.cyc);
                end
            end
        end
    end

    task automatic push_exp(input int a, input logic [63:0] ex, input int e0);
        qa.push_back('{ex, e0 + (a + STEP_A - 1) / STEP_A + 1});
        qb.push_back('{ex, e0 + (a + STEP_B - 1) / STEP_B + 1});
    endtask

    task automatic wait_idle(input string nm);
        bit fin;
        fin = 1'b0;
        for (int n = 0; n < 300; n++) begin
            if (!busy_a && !busy_b) begin
                fin = 1'b1;
                break;
            end
            @(negedge clock);
        end
        if (!fin) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout busy_a=%b busy_b=%b required=0", nm, busy_a, busy_b);
        end
    endtask

    task automatic run_op(input logic [1:0] m, input logic [5:0] a, input logic [63:0] op,
                          input logic [63:0] ex, input string nm);
        int  ai, ba, bb;
        bit  fin;
        ai = int'(a);
        @(negedge clock);
        start = 1'b1; mode = m; amount = a; operand = op;
        push_exp(ai, ex, cyc + 1);
        @(negedge clock);
        start = 1'b0;
        ba = 0; bb = 0; fin = 1'b0;
        for (int n = 0; n < 300; n++) begin
            if (!busy_a && !busy_b) begin
                fin = 1'b1;
                break;
            end
            if (busy_a) ba++;
            if (busy_b) bb++;
            @(negedge clock);
        end
        if (!fin) $display("FAIL %s_timeout busy still high after 300 cycles", nm);
        check({nm, "_busy_a"}, fin ? 64'(ba) : 64'hFFFF, 64'((ai + STEP_A - 1) / STEP_A + 2));
        check({nm, "_busy_b"}, fin ? 64'(bb) : 64'hFFFF, 64'((ai + STEP_B - 1) / STEP_B + 2));
    endtask

    initial begin
        logic [1:0]  rm;
        logic [5:0]  ra;
        logic [63:0] rop;

        vecs[0]  = '{2'b00, 6'd63, 64'h0000_0000_0000_0001, 64'h8000_0000_0000_0000};
        vecs[1]  = '{2'b10, 6'd4,  64'hF000_0000_0000_0000, 64'hFF00_0000_0000_0000};
        vecs[2]  = '{2'b01, 6'd4,  64'hF000_0000_0000_0000, 64'h0F00_0000_0000_0000};
        vecs[3]  = '{2'b11, 6'd6,  64'h8000_0000_0000_0001, 64'h0000_0000_0000_0060};
        vecs[4]  = '{2'b00, 6'd0,  64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567};
        vecs[5]  = '{2'b10, 6'd0,  64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567};
        vecs[6]  = '{2'b10, 6'd63, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[7]  = '{2'b01, 6'd63, 64'h8000_0000_0000_0000, 64'h0000_0000_0000_0001};
        vecs[8]  = '{2'b11, 6'd63, 64'h0000_0000_0000_0001, 64'h8000_0000_0000_0000};
        vecs[9]  = '{2'b10, 6'd8,  64'h7F00_0000_0000_0000, 64'h007F_0000_0000_0000};
        vecs[10] = '{2'b00, 6'd5,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFE0};
        vecs[11] = '{2'b11, 6'd4,  64'h0123_4567_89AB_CDEF, 64'h1234_5678_9ABC_DEF0};

        reset_n = 1'b0; start = 1'b0; mode = 2'b00; amount = '0; operand = '0; flush = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_busy", {62'd0, busy_a, busy_b}, 64'd0);
        check("rst_done", {62'd0, done_a, done_b}, 64'd0);
        check("rst_result_a", res_a, 64'd0);
        check("rst_result_b", res_b, 64'd0);
        reset_n = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 12; i++)
            run_op(vecs[i].m, vecs[i].a, vecs[i].op, vecs[i].ex, $sformatf("vec%0d", i));

        for (int i = 0; i < 16; i++) begin
            rm  = 2'($urandom_range(0, 3));
            ra  = 6'($urandom_range(0, 63));
            rop = {$urandom, $urandom};
            run_op(rm, ra, rop, model(rm, int'(ra), rop), $sformatf("rnd%0d", i));
        end

        // start held high: ignored in SHIFT and DONE, accepted again on the first IDLE cycle
        @(negedge clock);
        start = 1'b1; mode = 2'b11; amount = 6'd0; operand = 64'hDEAD_BEEF_0123_4567;
        push_exp(0, 64'hDEAD_BEEF_0123_4567, cyc + 1);
        push_exp(0, 64'hDEAD_BEEF_0123_4567, cyc + 4);
        @(negedge clock);
        check("hold_busy_shift", {62'd0, busy_a, busy_b}, 64'd3);
        @(negedge clock);
        check("hold_done", {62'd0, done_a, done_b}, 64'd3);
        @(negedge clock);
        check("hold_idle", {62'd0, busy_a, busy_b}, 64'd0);
        @(negedge clock);
        check("hold_reaccept", {62'd0, busy_a, busy_b}, 64'd3);
        start = 1'b0;
        wait_idle("hold");

        // flush in the 5th SHIFT cycle, with a competing start that must not be taken
        @(negedge clock);
        start = 1'b1; mode = 2'b00; amount = 6'd20; operand = 64'h1;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        check("flush_pre_busy", {62'd0, busy_a, busy_b}, 64'd3);
        flush = 1'b1; start = 1'b1; operand = 64'h55;
        @(negedge clock);
        flush = 1'b0; start = 1'b0;
        check("flush_busy", {62'd0, busy_a, busy_b}, 64'd0);
        check("flush_result_a", res_a, 64'hDEAD_BEEF_0123_4567);
        check("flush_result_b", res_b, 64'hDEAD_BEEF_0123_4567);
        repeat (3) @(negedge clock);
        check("flush_stays_idle", {62'd0, busy_a, busy_b}, 64'd0);

        // asynchronous reset between edges during SHIFT
        @(negedge clock);
        start = 1'b1; mode = 2'b00; amount = 6'd20; operand = 64'h3;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_busy", {62'd0, busy_a, busy_b}, 64'd0);
        check("arst_done", {62'd0, done_a, done_b}, 64'd0);
        check("arst_result_a", res_a, 64'd0);
        check("arst_result_b", res_b, 64'd0);
        @(negedge clock);
        reset_n = 1'b1;

        run_op(2'b01, 6'd8, 64'h100, 64'h1, "post_rst_srl");

        // start while busy is dropped, not queued
        @(negedge clock);
        start = 1'b1; mode = 2'b01; amount = 6'd8; operand = 64'h100;
        push_exp(8, 64'h1, cyc + 1);
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        start = 1'b1; mode = 2'b00; amount = 6'd3; operand = 64'hFF;
        @(negedge clock);
        start = 1'b0;
        wait_idle("busy_start");
        repeat (4) @(negedge clock);
        check("busy_start_ignored", {62'd0, busy_a, busy_b}, 64'd0);
        check("busy_start_result_a", res_a, 64'h1);
        check("busy_start_result_b", res_b, 64'h1);

        check("qa_drained", 64'(qa.size()), 64'd0);
        check("qb_drained", 64'(qb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
